// File: rtl/time_set_sequencer.sv
// time_set_sequencer: HH:MM:SS timekeeping with set-mode single-step/auto-repeat button handling
module time_set_sequencer #(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int CNT_W        = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       setting,
   input  logic       setting_h,
   input  logic       setting_m,
   input  logic       inc_n,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       day_pulse,
   output logic       repeat_active
);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   state_t state, state_n;
   logic s1, s2, s3, v1, v2, armed, setting_q, step, cnt_clr, press;
   logic [CNT_W-1:0] cnt;
   // armed only after a genuine released level has passed the synchronizer, so a button held through reset is not a press
   assign press = armed & s3 & ~s2;
   always_comb begin
      state_n = state;
      step = 1'b0;
      cnt_clr = 1'b0;
      if (!setting) state_n = IDLE;
      else if (state == IDLE) begin
         if (press) begin
            step = 1'b1;
            state_n = HOLD;
            cnt_clr = 1'b1;
         end
      end
      else if (s2) state_n = IDLE;
      else if (state == HOLD && cnt == CNT_W'(REPEAT_DELAY - 1)) begin
         step = 1'b1;
         state_n = REPEAT;
         cnt_clr = 1'b1;
      end
      else if (state == REPEAT && cnt == CNT_W'(REPEAT_RATE - 1)) begin
         step = 1'b1;
         cnt_clr = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {s1, s2, s3} <= 3'b111;
         {v1, v2, armed} <= 3'b000;
         state <= IDLE;
         cnt <= '0;
         repeat_active <= 1'b0;
      end else begin
         s1 <= inc_n;
         s2 <= s1;
         s3 <= s2;
         v1 <= 1'b1;
         v2 <= v1;
         armed <= armed | (v2 & s2);
         state <= state_n;
         cnt <= (cnt_clr || state_n == IDLE) ? '0 : cnt + 1'b1;
         repeat_active <= state_n == REPEAT;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         hours <= '0;
         minutes <= '0;
         seconds <= '0;
         day_pulse <= 1'b0;
         setting_q <= 1'b0;
      end else begin
         setting_q <= setting;
         day_pulse <= 1'b0;
         if (setting) begin
            if (!setting_q) seconds <= '0;
            if (step && setting_h) hours <= (hours == 5'd23) ? '0 : hours + 5'd1;
            else if (step && setting_m) minutes <= (minutes == 6'd59) ? '0 : minutes + 6'd1;
         end else if (tick_1hz) begin
            seconds <= (seconds == 6'd59) ? '0 : seconds + 6'd1;
            if (seconds == 6'd59) begin
               minutes <= (minutes == 6'd59) ? '0 : minutes + 6'd1;
               if (minutes == 6'd59) begin
                  hours <= (hours == 5'd23) ? '0 : hours + 5'd1;
                  day_pulse <= hours == 5'd23;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_time_set_sequencer.sv
// tb_time_set_sequencer: directed stimulus checked every cycle against a seconds-count/hold-time model
module tb_time_set_sequencer;
   localparam int RD = 20, RR = 5;
   logic clk = 0, rst = 1, tick_1hz = 0, setting = 0, setting_h = 0, setting_m = 0, inc_n = 1;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic day_pulse, repeat_active;
   int n_chk = 0, n_fail = 0;
   bit live = 0;
   time_set_sequencer #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .setting(setting), .setting_h(setting_h),
      .setting_m(setting_m), .inc_n(inc_n), .hours(hours), .minutes(minutes), .seconds(seconds),
      .day_pulse(day_pulse), .repeat_active(repeat_active));
   always #5 clk = ~clk;
   task automatic chk(string nm, int got, int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
      end
   endtask
   // model: time as a seconds count, button as press detection plus hold duration
   int mh, mm, ms, hold, nv, t;
   bit mday, mrep, d1, d2, d3, armed, act, ps, lvl, stp;
   always @(posedge clk) begin
      if (rst) begin
         mh = 0; mm = 0; ms = 0; mday = 0; mrep = 0; hold = 0; nv = 0;
         d1 = 1; d2 = 1; d3 = 1; armed = 0; act = 0; ps = 0;
      end else begin
         lvl = d2;
         stp = 0;
         mday = 0;
         if (!setting || lvl) act = 0;
         else if (!act) begin
            if (armed && d3) begin act = 1; hold = 0; stp = 1; end
         end else begin
            hold++;
            stp = hold == RD || (hold > RD && (hold - RD) % RR == 0);
         end
         mrep = act && hold >= RD;
         if (setting) begin
            if (!ps) ms = 0;
            if (stp && setting_h) mh = (mh + 1) % 24;
            else if (stp && setting_m) mm = (mm + 1) % 60;
         end else if (tick_1hz) begin
            t = (mh * 3600 + mm * 60 + ms + 1) % 86400;
            mday = t == 0;
            mh = t / 3600; mm = t / 60 % 60; ms = t % 60;
         end
         armed = armed | (nv >= 2 && lvl);
         nv = nv < 3 ? nv + 1 : 3;
         ps = setting;
         d3 = d2; d2 = d1; d1 = inc_n;
      end
   end
   always @(negedge clk) if (live) begin
      chk("hours", hours, mh);
      chk("minutes", minutes, mm);
      chk("seconds", seconds, ms);
      chk("day_pulse", day_pulse, mday);
      chk("repeat_active", repeat_active, mrep);
   end
   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic tick();
      tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(1);
   endtask
   task automatic press(int k);
      inc_n = 0; cyc(k); inc_n = 1; cyc(6);
   endtask
   initial begin
      cyc(3);
      live = 1;
      chk("rst_h", hours, 0); chk("rst_m", minutes, 0); chk("rst_s", seconds, 0);
      chk("rst_rep", repeat_active, 0);
      rst = 0; cyc(1);
      repeat (60) tick();
      chk("t1_s", seconds, 0); chk("t1_m", minutes, 1); chk("t1_h", hours, 0);
      setting = 1; setting_h = 1; cyc(1);
      repeat (23) press(3);
      setting_h = 0; setting_m = 1;
      repeat (58) press(3);
      setting_m = 0; setting = 0; cyc(1);
      chk("t2_h", hours, 23); chk("t2_m", minutes, 59); chk("t2_s0", seconds, 0);
      repeat (58) tick();
      chk("t2_s58", seconds, 58);
      tick();
      chk("t2_s59", seconds, 59); chk("t2_day0", day_pulse, 0);
      tick_1hz = 1; cyc(1); tick_1hz = 0;
      chk("t2_day1", day_pulse, 1); chk("t2_h0", hours, 0); chk("t2_m0", minutes, 0); chk("t2_s0b", seconds, 0);
      cyc(1);
      chk("t2_day_end", day_pulse, 0);
      setting = 1; setting_m = 1; cyc(1);
      repeat (58) press(3);
      chk("t3_m58", minutes, 58);
      press(5);
      chk("t3_m59", minutes, 59); chk("t3_rep0", repeat_active, 0);
      inc_n = 0;
      for (int j = 1; j <= 40; j++) begin
         cyc(1);
         if (j == 2) chk("t3_j2", minutes, 59);
         if (j == 3) chk("t3_j3", minutes, 0);
         if (j == 22) begin chk("t3_j22", minutes, 0); chk("t3_j22r", repeat_active, 0); end
         if (j == 23) begin chk("t3_j23", minutes, 1); chk("t3_j23r", repeat_active, 1); end
         if (j == 28) chk("t3_j28", minutes, 2);
         if (j == 33) chk("t3_j33", minutes, 3);
         if (j == 38) chk("t3_j38", minutes, 4);
         if (j == 40) chk("t3_j40r", repeat_active, 1);
      end
      inc_n = 1; cyc(6);
      chk("t3_end_m", minutes, 4); chk("t3_end_r", repeat_active, 0); chk("t3_end_h", hours, 0);
      repeat (6) press(3);
      setting_m = 0; setting_h = 1;
      repeat (23) press(3);
      chk("t4_h23", hours, 23); chk("t4_m10", minutes, 10);
      setting_m = 1;
      press(3);
      chk("t4_h", hours, 0); chk("t4_m", minutes, 10); chk("t4_day", day_pulse, 0);
      setting_h = 0; setting_m = 0;
      tick_1hz = 1; cyc(100); tick_1hz = 0; cyc(1);
      chk("t5_s", seconds, 0); chk("t5_m", minutes, 10); chk("t5_h", hours, 0);
      setting = 0; tick();
      chk("t5_s1", seconds, 1);
      setting = 1; setting_m = 1; cyc(1);
      inc_n = 0; cyc(30);
      chk("t6_rep", repeat_active, 1); chk("t6_m", minutes, 13);
      rst = 1; cyc(1);
      chk("t6_rh", hours, 0); chk("t6_rm", minutes, 0); chk("t6_rs", seconds, 0);
      chk("t6_rrep", repeat_active, 0); chk("t6_rday", day_pulse, 0);
      rst = 0; cyc(30);
      chk("t6_held_m", minutes, 0); chk("t6_held_r", repeat_active, 0);
      inc_n = 1; cyc(6);
      press(3);
      chk("t6_repress", minutes, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
